// File: rtl/piso_shift_tx_if.sv
// Load/serial bundle for the PISO transmitter: the source drives the word
// and handshake; the transmitter returns ready, serial data and framing strobes.
interface piso_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] PI;
    logic             LOAD_VALID;
    logic             LOAD_READY;
    logic             LEFT_RIGHT;
    logic             SO;
    logic             SO_VALID;
    logic             DONE;

    modport master (
        output PI, LOAD_VALID, LEFT_RIGHT,
        input  LOAD_READY, SO, SO_VALID, DONE
    );

    modport slave (
        input  PI, LOAD_VALID, LEFT_RIGHT,
        output LOAD_READY, SO, SO_VALID, DONE
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: takes a word over valid/ready and shifts
// it out one bit per clock, LSB- or MSB-first as selected with the word.
module piso_shift_tx #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic           C,
    input  logic           RST,
    piso_shift_tx_if.slave bus
);
    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_SHIFT = 1'b1;
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;

    logic last_bit;
    logic load_ready;
    logic accept;

    assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST);
    // A new word may be taken while the last bit of the current one is on SO.
    assign load_ready = ~RST & ((state_q == ST_IDLE) | last_bit);
    assign accept     = bus.LOAD_VALID & load_ready;

    assign bus.LOAD_READY = load_ready;
    assign bus.SO_VALID   = (state_q == ST_SHIFT);
    assign bus.DONE       = last_bit;
    assign bus.SO         = (state_q == ST_SHIFT) ? (dir_q ? sr_q[0] : sr_q[WIDTH-1]) : 1'b0;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (accept) begin
            state_d = ST_SHIFT;
            sr_d    = bus.PI;
            cnt_d   = '0;
            dir_d   = bus.LEFT_RIGHT;
        end else if (state_q == ST_SHIFT) begin
            sr_d = dir_q ? (sr_q >> 1) : (sr_q << 1);
            if (last_bit) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge C) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: directed vector table, hand-written
// corner sequences and randomized traffic against a bit-queue reference model.
module tb_piso_shift_tx;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(W)) bus ();

    piso_shift_tx #(.WIDTH(W)) dut (
        .C   (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic b;
        logic last;
    } ent_t;

    typedef struct {
        logic         rst;
        logic         valid;
        logic [W-1:0] pi;
        logic         lr;
        logic         so;
        logic         sov;
        logic         done;
        logic         rdy;
    } vec_t;

    ent_t q[$];
    logic bit_log[$];
    int   checks = 0;
    int   errors = 0;
    logic act_so, act_sov, act_done, act_rdy, last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input logic r, input logic v, input logic [W-1:0] p, input logic l);
        logic e_so, e_sov, e_done, e_rdy;
        @(negedge clk);
        rst            = r;
        bus.LOAD_VALID = v;
        bus.PI         = p;
        bus.LEFT_RIGHT = l;
        #1;
        e_sov  = (q.size() > 0);
        e_so   = e_sov ? q[0].b : 1'b0;
        e_done = e_sov ? q[0].last : 1'b0;
        e_rdy  = !r && (!e_sov || q[0].last);
        act_so   = bus.SO;
        act_sov  = bus.SO_VALID;
        act_done = bus.DONE;
        act_rdy  = bus.LOAD_READY;
        if (act_sov === 1'b1) bit_log.push_back(act_so);
        chk("model_so",    32'(act_so),   32'(e_so));
        chk("model_sov",   32'(act_sov),  32'(e_sov));
        chk("model_done",  32'(act_done), 32'(e_done));
        chk("model_ready", 32'(act_rdy),  32'(e_rdy));
        @(posedge clk);
        last_acc = v && e_rdy;
        if (r) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (last_acc) begin
                for (int i = 0; i < W; i++)
                    q.push_back('{b: (l ? p[i] : p[W-1-i]), last: (i == W-1)});
            end
        end
    endtask

    function automatic logic [31:0] packed_log();
        logic [31:0] val = '0;
        foreach (bit_log[i]) val = {val[30:0], bit_log[i]};
        return val;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[12];
        logic [W-1:0] word;
        logic [W-1:0] rnd_pi;
        logic         rnd_lr;

        rst = 1'b1;
        bus.LOAD_VALID = 1'b1;
        bus.PI = 8'hA5;
        bus.LEFT_RIGHT = 1'b1;
        repeat (2) @(posedge clk);

        // Reset with a word on offer, then one LSB-first word 0xB4.
        word = 8'hB4;
        for (int i = 0; i < 2; i++) tbl[i] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, word, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < W; i++)
            tbl[3+i] = '{1'b0, 1'b0, 8'h00, 1'b0, word[i], 1'b1, (i == W-1), (i == W-1)};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].valid, tbl[i].pi, tbl[i].lr);
            chk($sformatf("tbl%0d_so", i),    32'(act_so),   32'(tbl[i].so));
            chk($sformatf("tbl%0d_sov", i),   32'(act_sov),  32'(tbl[i].sov));
            chk($sformatf("tbl%0d_done", i),  32'(act_done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_ready", i), 32'(act_rdy),  32'(tbl[i].rdy));
        end

        // MSB-first 0xB4 looped into a shift-left receiver.
        bit_log.delete();
        step(1'b0, 1'b1, 8'hB4, 1'b0);
        repeat (W + 1) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("msb_count", 32'(bit_log.size()), 32'd8);
        chk("msb_rx", packed_log(), 32'hB4);

        // Back-to-back: 0x0F LSB-first then 0xF0 MSB-first offered continuously.
        bit_log.delete();
        step(1'b0, 1'b1, 8'h0F, 1'b1);
        repeat (W) step(1'b0, 1'b1, 8'hF0, 1'b0);
        repeat (W) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("b2b_count", 32'(bit_log.size()), 32'd16);
        chk("b2b_bits", packed_log(), 32'b1111_0000_1111_0000);

        // Inputs change mid-word: 0x81 must go out untouched, 0x7E follows.
        bit_log.delete();
        step(1'b0, 1'b1, 8'h81, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h81, 1'b1);
        repeat (6) step(1'b0, 1'b1, 8'h7E, 1'b0);
        repeat (W + 1) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mid_count", 32'(bit_log.size()), 32'd16);
        chk("mid_bits", packed_log(), 32'b1000_0001_0111_1110);

        // Reset during bit 4 of 0xFF, then 0x01 LSB-first.
        bit_log.delete();
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b1);
        chk("rst_idle_sov", 32'(act_sov), 32'd0);
        chk("rst_idle_ready", 32'(act_rdy), 32'd1);
        repeat (W + 1) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_count", 32'(bit_log.size()), 32'd12);
        chk("rst_bits", packed_log(), 32'b1111_1000_0000);

        // Randomized traffic; the source holds its word until it is accepted.
        rnd_pi = 8'($urandom);
        rnd_lr = 1'($urandom);
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), rnd_pi, rnd_lr);
            if (last_acc) begin
                rnd_pi = 8'($urandom);
                rnd_lr = 1'($urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
